// File: rtl/chinpo_pkg.sv
// Shared definitions for the CHINPO memory interface: FSM encoding,
// capture destinations, opcode field position and watchdog limit.
package chinpo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        DST_IR  = 1'b0,
        DST_MDR = 1'b1
    } dst_e;

    localparam int unsigned OPC_MSB     = 15;
    localparam int unsigned OPC_LSB     = 12;
    localparam int unsigned TIMEOUT_MAX = 255;

endpackage

// File: rtl/chinpo_mem_interface_if.sv
// Memory-side req/ack bus of the CHINPO memory interface.
interface chinpo_mem_interface_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/chinpo_mem_watchdog.sv
// ACCESS-cycle watchdog; expired is high in the TIMEOUT_MAX-th ACCESS cycle.
module chinpo_mem_watchdog
    import chinpo_pkg::*;
(
    input  logic CLK,
    input  logic Reset,
    input  logic start,
    input  logic active,
    output logic expired
);
    logic [7:0] count;

    always_ff @(posedge CLK) begin
        if (Reset || start) begin
            count <= '0;
        end else if (active) begin
            count <= count + 8'd1;
        end
    end

    assign expired = active && (count == 8'(TIMEOUT_MAX - 1));
endmodule

// File: rtl/chinpo_mem_interface.sv
// Registered req/ack bridge between the CHINPO control unit and memory; owns IR and MDR.
// Optional ACCESS watchdog with sticky MemErr when CHINPO_MEM_TIMEOUT_EN is defined.
module chinpo_mem_interface
    import chinpo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   IRWrite,
    input  logic                   MemRead,
    input  logic                   MemWrite,
    input  logic                   MemAddr,
    input  logic [ADDR_W-1:0]      PC,
    input  logic [ADDR_W-1:0]      ALUOut,
    input  logic [DATA_W-1:0]      StoreData,
    chinpo_mem_interface_if.master mem,
    output logic [DATA_W-1:0]      IR,
    output logic [3:0]             Opcode,
    output logic                   IR3,
    output logic                   IR2,
    output logic                   IR1,
    output logic                   IR0,
    output logic [DATA_W-1:0]      MDR,
    output logic                   Busy,
    output logic                   MemErr
);
    state_e            state, next_state;
    dst_e              dst_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              request, start, timeout;

    assign request = IRWrite | MemWrite | MemRead;
    assign start   = (state == IDLE) && request;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (request) next_state = ACCESS;
            ACCESS:  if (mem.mem_ack || timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dst_q   <= DST_IR;
            IR      <= '0;
            MDR     <= '0;
        end else begin
            state <= next_state;
            req_q <= (next_state == ACCESS);
            // IRWrite outranks the data strobes: fetches always use PC and read
            if (start) begin
                addr_q  <= (IRWrite || !MemAddr) ? PC : ALUOut;
                we_q    <= !IRWrite && MemWrite;
                wdata_q <= StoreData;
                dst_q   <= IRWrite ? DST_IR : DST_MDR;
            end
            if (state == ACCESS && mem.mem_ack && !we_q) begin
                if (dst_q == DST_IR) IR  <= mem.mem_rdata;
                else                 MDR <= mem.mem_rdata;
            end
        end
    end

`ifdef CHINPO_MEM_TIMEOUT_EN
    logic err_q;

    chinpo_mem_watchdog u_watchdog (
        .CLK    (CLK),
        .Reset  (Reset),
        .start  (start),
        .active (state == ACCESS),
        .expired(timeout)
    );

    // An ack in the expiring cycle still wins and is not an error
    always_ff @(posedge CLK) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (state == ACCESS && timeout && !mem.mem_ack) begin
            err_q <= 1'b1;
        end
    end

    assign MemErr = err_q;
`else
    assign timeout = 1'b0;
    assign MemErr  = 1'b0;
`endif

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign Busy   = !Reset && (start || state == ACCESS);
    assign Opcode = IR[OPC_MSB:OPC_LSB];
    assign IR3    = IR[3];
    assign IR2    = IR[2];
    assign IR1    = IR[1];
    assign IR0    = IR[0];
endmodule

// File: doc/chinpo_mem_interface.md
# chinpo_mem_interface

- Sits between the CHINPO multicycle control unit and the single-port instruction/data memory.
- Turns the control unit's IRWrite / MemRead / MemWrite / MemAddr strobes into a registered req/ack memory transaction.
- Captures instruction words into the instruction register (IR) and load data into the memory data register (MDR).
- Drives Opcode and IR0–IR3 back to the control unit, and raises Busy so the top level can hold the control unit's state register while memory is slow.

## Interface
Parameters:
- DATA_W, 16, word width (instruction and data)
- ADDR_W, 16, memory address width

Ports:
- CLK  in  1  rising-edge clock, the only clock
- Reset  in  1  synchronous, active-high reset
- IRWrite  in  1  instruction fetch request (Fetch state)
- MemRead  in  1  data load request
- MemWrite  in  1  data store request
- MemAddr  in  1  address select: 0 = PC, 1 = ALUOut
- PC  in  ADDR_W  program counter
- ALUOut  in  ADDR_W  computed data address
- StoreData  in  DATA_W  register-file B operand for stores
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle transaction completion
- IR  out  DATA_W  instruction register
- Opcode  out  4  IR[15:12]
- IR3, IR2, IR1, IR0  out  1 each  IR[3], IR[2], IR[1], IR[0]
- MDR  out  DATA_W  load data register
- Busy  out  1  stall; the top level gates control-unit state advance with it
- MemErr  out  1  sticky timeout flag (only when the timeout feature is compiled in)

## Operation
- FSM states and transitions:
  - IDLE: if a request is seen, go to ACCESS; otherwise stay in IDLE.
  - ACCESS: on mem_ack, go to DONE.
  - DONE: always go to IDLE.
- Request in IDLE = IRWrite | MemWrite | MemRead. Priority IRWrite > MemWrite > MemRead; lower-priority strobes asserted at the same time are ignored.
- On the IDLE→ACCESS edge, register:
  - mem_addr = PC when IRWrite; otherwise (MemAddr ? ALUOut : PC)
  - mem_we = 1 only for MemWrite
  - mem_wdata = StoreData
  - the destination, IR or MDR
- ACCESS: mem_req=1. mem_addr, mem_we and mem_wdata stay stable until mem_ack.
- ACCESS with mem_ack on a read: mem_rdata is written into the destination register (IR or MDR) at that edge. The other register is unchanged. Writes update neither.
- DONE: ignores all strobes, because the control unit still presents the old request during this cycle. mem_req=0.
- Busy = (IDLE & request) | ACCESS. Busy=0 in DONE and in IDLE with no request. Busy is forced to 0 while Reset is high.
- mem_ack outside ACCESS is ignored.
- Opcode and IR0–IR3 are pure slices of IR.

## Timing
- Reset values: IR=0, MDR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, MemErr=0, state=IDLE. Opcode and IR bits are 0.
- Request seen in cycle T. mem_req is high from T+1.
- mem_ack arrives in cycle T+k (k≥1). IR/MDR hold the new value from T+k+1, and Busy=0 in T+k+1 (DONE).
- Minimum access is 3 cycles, IDLE through DONE. The next request can be accepted at T+k+2.
- Reset asserted mid-ACCESS: at the next edge mem_req drops to 0, the state returns to IDLE, and any late ack is ignored.

## Configuration
- CHINPO_MEM_TIMEOUT_EN defined:
  - An 8-bit watchdog counts ACCESS cycles.
  - When the count reaches 255 without ack, the block moves to DONE, leaves IR/MDR unchanged, and sets MemErr (sticky until Reset). The watchdog clears on IDLE→ACCESS.
- Not defined: ACCESS waits indefinitely. MemErr is tied to 0 and no counter logic exists.

## Structure
- Shared package chinpo_pkg holds:
  - the FSM state encoding (IDLE=0, ACCESS=1, DONE=2)
  - the destination select constants (DST_IR, DST_MDR)
  - the opcode field position constants (OPC_MSB=15, OPC_LSB=12)
  - TIMEOUT_MAX=255
- One sub-module is natural: chinpo_mem_watchdog, the timeout counter, instantiated only under CHINPO_MEM_TIMEOUT_EN.

## Test plan
- Reset, then IRWrite=1, PC=0x0040, mem_ack after 2 ACCESS cycles with rdata=0xA123:
  - mem_addr=0x0040 and mem_we=0 during ACCESS
  - IR=0xA123, Opcode=0xA and IR3..IR0=0011 after the ack
  - Busy low exactly in the DONE cycle
- MemRead=1, MemAddr=1, ALUOut=0x0100, ack with rdata=0x5555: MDR=0x5555, IR unchanged.
- MemWrite=1, MemAddr=1, ALUOut=0x0200, StoreData=0xBEEF:
  - mem_we=1, mem_wdata=0xBEEF and mem_addr=0x0200 are held stable over a 5-cycle ack delay
  - IR and MDR unchanged
- IRWrite and MemWrite asserted together: mem_addr=PC, mem_we=0, the fetch result goes to IR.
- Reset during ACCESS, with ack arriving one cycle later: mem_req=0, IR/MDR=0, the late ack causes no capture.
- With CHINPO_MEM_TIMEOUT_EN and no ack:
  - DONE after 255 ACCESS cycles, MemErr=1, IR unchanged
  - the next fetch still completes normally
